// File: rtl/crop_layer_pkg.sv
// Shared elaboration helpers for the crop stage.
// Counter widths are sized here so that a 1-pixel dimension still gets a 1-bit counter.
package crop_layer_pkg;

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/crop_layer_stream_fifo2.sv
// Generic 2-entry valid/ready staging FIFO; every output comes straight from registers.
// A full FIFO deasserts in_ready from its registered count only, never from out_ready.
module stream_fifo2 #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             push;
   logic             pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = mem[rd_ptr];

   // A push with a pop at count==1 writes the free slot while the head drains, keeping order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/crop_layer.sv
// Strips a fixed border from a raster-order pixel stream and forwards only the interior.
// Border pixels are always consumed, even under backpressure; frames run back-to-back.
module crop_layer
   import crop_layer_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int IMG_WIDTH   = 17,
   parameter int IMG_HEIGHT  = 17,
   parameter int CROP_TOP    = 1,
   parameter int CROP_BOTTOM = 2,
   parameter int CROP_LEFT   = 1,
   parameter int CROP_RIGHT  = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         valid_in,
   input  logic signed [DATA_WIDTH-1:0] data_in,
   output logic                         ready_in,
   output logic                         valid_out,
   output logic signed [DATA_WIDTH-1:0] data_out,
   output logic                         last_out,
   input  logic                         ready_out,
   output logic                         frame_done
);

   localparam int OUT_W = IMG_WIDTH - CROP_LEFT - CROP_RIGHT;
   localparam int OUT_H = IMG_HEIGHT - CROP_TOP - CROP_BOTTOM;
   localparam int XW    = cnt_width(IMG_WIDTH);
   localparam int YW    = cnt_width(IMG_HEIGHT);

   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

   generate
      if (OUT_W < 1 || OUT_H < 1) begin : g_bad_crop
         $error("crop_layer: crop leaves an empty output frame");
      end
   endgenerate

   // Stream contract (input and output alike): a beat transfers on a clock edge where
   // valid and ready are both high; a raised valid holds its data until that transfer.

   logic [XW-1:0]         in_x;
   logic [YW-1:0]         in_y;
   logic                  x_kept;
   logic                  y_kept;
   logic                  keep;
   logic                  at_x_end;
   logic                  at_y_end;
   logic                  kept_last;
   logic                  fire_in;
   logic                  fifo_ready;
   logic [DATA_WIDTH:0]   fifo_head;

   assign x_kept    = (int'(in_x) >= CROP_LEFT) && (int'(in_x) < IMG_WIDTH - CROP_RIGHT);
   assign y_kept    = (int'(in_y) >= CROP_TOP)  && (int'(in_y) < IMG_HEIGHT - CROP_BOTTOM);
   assign keep      = x_kept && y_kept;
   assign at_x_end  = (in_x == X_LAST);
   assign at_y_end  = (in_y == Y_LAST);
   assign kept_last = (int'(in_x) == IMG_WIDTH - CROP_RIGHT - 1) &&
                      (int'(in_y) == IMG_HEIGHT - CROP_BOTTOM - 1);

   // Only interior pixels need buffer space, so a border pixel is accepted even when full.
   assign ready_in = !keep || fifo_ready;
   assign fire_in  = valid_in && ready_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_x       <= '0;
         in_y       <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= fire_in && at_x_end && at_y_end;
         if (fire_in) begin
            if (at_x_end) begin
               in_x <= '0;
               in_y <= at_y_end ? '0 : in_y + YW'(1);
            end else begin
               in_x <= in_x + XW'(1);
            end
         end
      end
   end

   stream_fifo2 #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_out_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (valid_in && keep),
      .in_ready  (fifo_ready),
      .in_data   ({kept_last, data_in}),
      .out_valid (valid_out),
      .out_ready (ready_out),
      .out_data  (fifo_head)
   );

   assign data_out = fifo_head[DATA_WIDTH-1:0];
   assign last_out = fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_crop_layer.sv
// Directed bench for crop_layer: default 17x17 instance plus a 4x4 right-crop corner instance.
// Inputs change 1 time unit after a rising edge; outputs and handshakes are sampled on falling edges.
module tb_crop_layer;

   localparam int DW    = 16;
   localparam int W     = 17;
   localparam int H     = 17;
   localparam int CT    = 1;
   localparam int CB    = 2;
   localparam int CL    = 1;
   localparam int CR    = 2;
   localparam int N_OUT = (W - CL - CR) * (H - CT - CB);

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic                 valid_in  = 1'b0;
   logic signed [DW-1:0] data_in   = '0;
   logic                 ready_in;
   logic                 valid_out;
   logic signed [DW-1:0] data_out;
   logic                 last_out;
   logic                 ready_out = 1'b0;
   logic                 frame_done;

   logic                 c_valid_in  = 1'b0;
   logic signed [DW-1:0] c_data_in   = '0;
   logic                 c_ready_in;
   logic                 c_valid_out;
   logic signed [DW-1:0] c_data_out;
   logic                 c_last_out;
   logic                 c_ready_out = 1'b1;
   logic                 c_frame_done;

   crop_layer #(
      .DATA_WIDTH (DW), .IMG_WIDTH (W), .IMG_HEIGHT (H),
      .CROP_TOP (CT), .CROP_BOTTOM (CB), .CROP_LEFT (CL), .CROP_RIGHT (CR)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .valid_in (valid_in), .data_in (data_in), .ready_in (ready_in),
      .valid_out (valid_out), .data_out (data_out), .last_out (last_out),
      .ready_out (ready_out), .frame_done (frame_done)
   );

   crop_layer #(
      .DATA_WIDTH (DW), .IMG_WIDTH (4), .IMG_HEIGHT (4),
      .CROP_TOP (0), .CROP_BOTTOM (0), .CROP_LEFT (0), .CROP_RIGHT (3)
   ) u_corner (
      .clk (clk), .rst_n (rst_n),
      .valid_in (c_valid_in), .data_in (c_data_in), .ready_in (c_ready_in),
      .valid_out (c_valid_out), .data_out (c_data_out), .last_out (c_last_out),
      .ready_out (c_ready_out), .frame_done (c_frame_done)
   );

   // ---------------- scoreboard state ----------------
   int n_cmp        = 0;
   int n_bad        = 0;
   int cyc          = 0;
   int fd_count     = 0;
   int c_fd_count   = 0;
   int fd_cyc       = -1;
   int last_acc_cyc = -1;
   int drv_timeouts = 0;
   logic [DW:0] got_q[$];
   logic [DW:0] exp_q[$];
   logic [DW:0] c_got_q[$];

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (valid_out && ready_out) got_q.push_back({last_out, data_out});
         if (valid_in && ready_in) last_acc_cyc = cyc;
         if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
         end
         if (c_valid_out && c_ready_out) c_got_q.push_back({c_last_out, c_data_out});
         if (c_frame_done) c_fd_count++;
      end
   end

   function automatic bit model_keep(input int x, input int y);
      return (x >= CL) && (x < W - CR) && (y >= CT) && (y < H - CB);
   endfunction

   function automatic logic [DW:0] model_pix(input int x, input int y);
      logic lst;
      lst = (x == W - CR - 1) && (y == H - CB - 1);
      return {lst, DW'(y * W + x)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send_pix(input int v, input bit gaps);
      int guard;
      if (gaps) begin
         while ($urandom_range(0, 1) == 0) begin
            valid_in = 1'b0;
            @(posedge clk); #1;
         end
      end
      valid_in = 1'b1;
      data_in  = DW'(v);
      guard    = 0;
      @(negedge clk);
      while (!ready_in && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (!ready_in) drv_timeouts++;
      @(posedge clk); #1;
      valid_in = 1'b0;
   endtask

   task automatic send_c(input int v);
      int guard;
      c_valid_in = 1'b1;
      c_data_in  = DW'(v);
      guard      = 0;
      @(negedge clk);
      while (!c_ready_in && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (!c_ready_in) drv_timeouts++;
      @(posedge clk); #1;
      c_valid_in = 1'b0;
   endtask

   task automatic send_frame(input bit gaps);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            send_pix(y * W + x, gaps);
   endtask

   task automatic add_frame_exp();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            if (model_keep(x, y)) exp_q.push_back(model_pix(x, y));
   endtask

   task automatic wait_outputs(input int n, output bit ok);
      int guard;
      guard = 0;
      while (got_q.size() < n && guard < 5000) begin
         @(negedge clk); #1;
         guard++;
      end
      ok = (got_q.size() >= n);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      valid_in   = 1'b0;
      c_valid_in = 1'b0;
      ready_out  = 1'b0;
      rst_n      = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      got_q.delete();
      c_got_q.delete();
      exp_q.delete();
      drv_timeouts = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1 rst_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
      n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_data_out: got %0h want 0", data_out); end
      n_cmp++; if (last_out !== 1'b0) begin n_bad++; $display("FAIL reset_last_out: got %b want 0", last_out); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      n_cmp++; if (ready_in !== 1'b1) begin n_bad++; $display("FAIL reset_ready_in: got %b want 1", ready_in); end
      n_cmp++; if (c_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_corner_valid: got %b want 0", c_valid_out); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_full_frame();
      bit ok;
      int n_last;
      int base_fd;
      got_q.delete();
      exp_q.delete();
      drv_timeouts = 0;
      base_fd   = fd_count;
      ready_out = 1'b1;
      add_frame_exp();
      send_frame(1'b0);
      wait_outputs(N_OUT, ok);
      n_cmp++; if (!ok || drv_timeouts != 0) begin n_bad++; $display("FAIL frame_timeout: got %0d outputs want %0d, %0d stalls", got_q.size(), N_OUT, drv_timeouts); end
      n_cmp++; if (got_q.size() != 196) begin n_bad++; $display("FAIL frame_count: got %0d want 196", got_q.size()); end
      n_cmp++; if (got_q[0] !== 17'h00012) begin n_bad++; $display("FAIL frame_first: got %0h want 12", got_q[0]); end
      n_cmp++; if (got_q[1] !== 17'h00013) begin n_bad++; $display("FAIL frame_second: got %0h want 13", got_q[1]); end
      n_cmp++; if (got_q[13] !== 17'h0001f || got_q[14] !== 17'h00023) begin n_bad++; $display("FAIL frame_row_wrap: got %0h,%0h want 1f,23", got_q[13], got_q[14]); end
      n_cmp++; if (got_q[195] !== 17'h100fc) begin n_bad++; $display("FAIL frame_last: got %0h want 100fc", got_q[195]); end
      n_last = 0;
      foreach (got_q[i]) if (got_q[i][DW]) n_last++;
      n_cmp++; if (n_last != 1) begin n_bad++; $display("FAIL frame_last_count: got %0d want 1", n_last); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL frame_sb[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]);
         end
      end
      n_cmp++; if (fd_count - base_fd != 1) begin n_bad++; $display("FAIL frame_done_count: got %0d want 1", fd_count - base_fd); end
      n_cmp++; if (fd_cyc != last_acc_cyc + 1) begin n_bad++; $display("FAIL frame_done_timing: got cycle %0d want %0d", fd_cyc, last_acc_cyc + 1); end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [DW:0] bp_exp[$];
      apply_reset();
      for (int v = 0; v < 20; v++) send_pix(v, 1'b0);
      valid_in = 1'b1;
      data_in  = DW'(20);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++; if (ready_in !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low: got %b want 0", ready_in); end
         n_cmp++; if (valid_out !== 1'b1 || data_out !== DW'(18)) begin n_bad++; $display("FAIL bp_head_hold: got v=%b d=%0d want v=1 d=18", valid_out, data_out); end
      end
      @(posedge clk); #1;
      ready_out = 1'b1;
      for (int v = 20; v < 30; v++) send_pix(v, 1'b0);
      wait_outputs(12, ok);
      ready_out = 1'b0;
      send_pix(30, 1'b0);
      send_pix(31, 1'b0);
      for (int v = 32; v < 35; v++) begin
         valid_in = 1'b1;
         data_in  = DW'(v);
         @(negedge clk);
         n_cmp++; if (ready_in !== 1'b1) begin n_bad++; $display("FAIL bp_border_accept: pixel %0d ready_in got %b want 1", v, ready_in); end
         @(posedge clk); #1;
      end
      valid_in = 1'b1;
      data_in  = DW'(35);
      @(negedge clk);
      n_cmp++; if (ready_in !== 1'b0) begin n_bad++; $display("FAIL bp_interior_stall: got %b want 0", ready_in); end
      @(posedge clk); #1;
      ready_out = 1'b1;
      send_pix(35, 1'b0);
      wait_outputs(15, ok);
      for (int v = 18; v < 32; v++) bp_exp.push_back({1'b0, DW'(v)});
      bp_exp.push_back(17'h00023);
      n_cmp++; if (!ok || got_q.size() != 15 || drv_timeouts != 0) begin n_bad++; $display("FAIL bp_count: got %0d outputs want 15, %0d stalls", got_q.size(), drv_timeouts); end
      for (int i = 0; i < bp_exp.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== bp_exp[i]) begin
            n_bad++;
            $display("FAIL bp_order[%0d]: got %0h want %0h", i, got_q[i], bp_exp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      bit done;
      int base_fd;
      apply_reset();
      base_fd = fd_count;
      for (int f = 0; f < 3; f++) add_frame_exp();
      done = 1'b0;
      fork
         begin
            for (int f = 0; f < 3; f++) send_frame(1'b1);
            done = 1'b1;
         end
         begin
            while (!done) begin
               ready_out = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            ready_out = 1'b1;
         end
      join
      wait_outputs(3 * N_OUT, ok);
      n_cmp++; if (!ok || drv_timeouts != 0) begin n_bad++; $display("FAIL b2b_timeout: got %0d outputs want 588, %0d stalls", got_q.size(), drv_timeouts); end
      n_cmp++; if (got_q.size() != 588) begin n_bad++; $display("FAIL b2b_count: got %0d want 588", got_q.size()); end
      n_cmp++; if (got_q[0] !== 17'h00012 || got_q[196] !== 17'h00012 || got_q[392] !== 17'h00012) begin n_bad++; $display("FAIL b2b_frame_start: got %0h,%0h,%0h want 12 each", got_q[0], got_q[196], got_q[392]); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL b2b_sb[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]);
         end
      end
      n_cmp++; if (fd_count - base_fd != 3) begin n_bad++; $display("FAIL b2b_frame_done: got %0d want 3", fd_count - base_fd); end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      apply_reset();
      ready_out = 1'b1;
      for (int v = 0; v < 98; v++) send_pix(v, 1'b0);
      repeat (3) @(posedge clk);
      #1 ready_out = 1'b0;
      send_pix(98, 1'b0);
      send_pix(99, 1'b0);
      @(negedge clk);
      n_cmp++; if (valid_out !== 1'b1 || data_out !== DW'(98)) begin n_bad++; $display("FAIL mid_buffered: got v=%b d=%0d want v=1 d=98", valid_out, data_out); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b want 0", valid_out); end
      n_cmp++; if (ready_in !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ready: got %b want 1", ready_in); end
      n_cmp++; if (frame_done !== 1'b0 || last_out !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags: got fd=%b last=%b want 0,0", frame_done, last_out); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      got_q.delete();
      exp_q.delete();
      drv_timeouts = 0;
      ready_out    = 1'b1;
      add_frame_exp();
      send_frame(1'b0);
      wait_outputs(N_OUT, ok);
      n_cmp++; if (!ok || got_q.size() != 196 || drv_timeouts != 0) begin n_bad++; $display("FAIL mid_frame_count: got %0d want 196, %0d stalls", got_q.size(), drv_timeouts); end
      n_cmp++; if (got_q[0] !== 17'h00012) begin n_bad++; $display("FAIL mid_first: got %0h want 12", got_q[0]); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL mid_sb[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_corner();
      int guard;
      apply_reset();
      c_ready_out = 1'b1;
      for (int v = 0; v < 16; v++) send_c(v);
      guard = 0;
      while (c_got_q.size() < 4 && guard < 100) begin
         @(negedge clk); #1;
         guard++;
      end
      repeat (4) @(posedge clk);
      #1;
      n_cmp++; if (c_got_q.size() != 4 || drv_timeouts != 0) begin n_bad++; $display("FAIL corner_count: got %0d want 4, %0d stalls", c_got_q.size(), drv_timeouts); end
      n_cmp++; if (c_got_q[0] !== 17'h00000) begin n_bad++; $display("FAIL corner_out0: got %0h want 0", c_got_q[0]); end
      n_cmp++; if (c_got_q[1] !== 17'h00004) begin n_bad++; $display("FAIL corner_out1: got %0h want 4", c_got_q[1]); end
      n_cmp++; if (c_got_q[2] !== 17'h00008) begin n_bad++; $display("FAIL corner_out2: got %0h want 8", c_got_q[2]); end
      n_cmp++; if (c_got_q[3] !== 17'h1000c) begin n_bad++; $display("FAIL corner_out3_last: got %0h want 1000c", c_got_q[3]); end
      n_cmp++; if (c_fd_count != 1) begin n_bad++; $display("FAIL corner_frame_done: got %0d want 1", c_fd_count); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_full_frame();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      test_corner();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
